// File: rtl/hero_asm_pkg.sv
// Widths, FSM states and the packet record shared by the hero beat assembler and its queue.
package hero_asm_pkg;

    localparam int MAX_BEATS = 4;
    localparam int DATA_W    = 36;
    localparam int TAG_W     = 5;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int IDX_W     = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD
    } asm_state_e;

    // Slot i of data maps to bits [i*DATA_W +: DATA_W] once flattened.
    typedef struct packed {
        logic [MAX_BEATS-1:0][DATA_W-1:0] data;
        logic [CNT_W-1:0]                 beats;
        logic [TAG_W-1:0]                 tag;
        logic                             err;
    } hero_pkt_t;

endpackage

// File: rtl/test_pkg_a.sv
// Hero bus beat classification shared with the test_pkg_a producers.
package test_pkg_a;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } CYCLE_TYPE_E;

endpackage

// File: rtl/hero_beat_assembler_if.sv
// Beat-in / packet-out bundle of the hero beat assembler; slave is the assembler side.
interface hero_beat_assembler_if;
    import hero_asm_pkg::*;

    test_pkg_a::CYCLE_TYPE_E       in_cycle_type;
    logic [DATA_W-1:0]             in_data;
    logic [TAG_W-1:0]              in_tag;
    logic                          in_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [MAX_BEATS*DATA_W-1:0]   out_data;
    logic [CNT_W-1:0]              out_beats;
    logic [TAG_W-1:0]              out_tag;
    logic                          out_err;

    modport slave (
        input  in_cycle_type, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_tag, out_err
    );

    modport master (
        output in_cycle_type, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_tag, out_err
    );

endinterface

// File: rtl/hero_pkt_fifo.sv
// Two-entry valid/ready packet queue; head reads as zero while empty.
module hero_pkt_fifo
    import hero_asm_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  hero_pkt_t push_pkt_i,
    output logic      full_o,
    output logic      valid_o,
    input  logic      pop_i,
    output hero_pkt_t head_o
);

    localparam int DEPTH = 2;

    hero_pkt_t  mem_q [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'(DEPTH));
    assign valid_o = (count_q != 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_pkt_i;
        end
    end

    assign head_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/hero_beat_assembler.sv
// Collects hero bus beats into packets (FSM + accumulator) and queues them for the consumer.
module hero_beat_assembler
    import hero_asm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    hero_beat_assembler_if.slave  bus
);

    asm_state_e state_q, state_d;
    hero_pkt_t  acc_q, acc_d;
    hero_pkt_t  beat_pkt;
    hero_pkt_t  push_pkt;
    hero_pkt_t  head;
    logic       accept;
    logic       close;
    logic       push;
    logic       fifo_full;
    logic       fifo_valid;

    // Accumulator with the current beat folded in; only committed when the beat is accepted.
    always_comb begin
        beat_pkt = acc_q;
        close    = 1'b0;
        accept   = (state_q != ST_HOLD) && (bus.in_cycle_type != test_pkg_a::IDLE);

        if (state_q == ST_IDLE) begin
            beat_pkt     = '0;
            beat_pkt.tag = bus.in_tag;
            beat_pkt.err = acc_q.err;
        end

        if (accept) begin
            case (bus.in_cycle_type)
                test_pkg_a::VALID, test_pkg_a::DONE: begin
                    if (beat_pkt.beats == CNT_W'(MAX_BEATS)) begin
                        beat_pkt.err = 1'b1;
                    end else begin
                        beat_pkt.data[beat_pkt.beats[IDX_W-1:0]] = bus.in_data;
                        beat_pkt.beats = beat_pkt.beats + CNT_W'(1);
                    end
                    if (bus.in_tag != beat_pkt.tag) begin
                        beat_pkt.err = 1'b1;
                    end
                    close = (bus.in_cycle_type == test_pkg_a::DONE);
                end
                default: beat_pkt.err = 1'b1;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        push     = 1'b0;
        push_pkt = beat_pkt;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    if (close) begin
                        if (!fifo_full) begin
                            push    = 1'b1;
                            acc_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            acc_d   = beat_pkt;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        acc_d = beat_pkt;
                        if (bus.in_cycle_type == test_pkg_a::VALID) begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
            end
            ST_HOLD: begin
                push_pkt = acc_q;
                if (!fifo_full) begin
                    push    = 1'b1;
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    hero_pkt_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_pkt_i (push_pkt),
        .full_o     (fifo_full),
        .valid_o    (fifo_valid),
        .pop_i      (bus.out_ready),
        .head_o     (head)
    );

    assign bus.in_ready  = (state_q != ST_HOLD);
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = head.data;
    assign bus.out_beats = head.beats;
    assign bus.out_tag   = head.tag;
    assign bus.out_err   = head.err;

endmodule
